// File: rtl/tcdm_seq_mux.sv
// tcdm_seq_mux: shares one TCDM master port among NB_CH stream ports.
// Channels are visited in a programmable weighted round-robin sequence
// (per-channel enable, per-channel burst length); responses are routed back
// through an in-order channel-ID FIFO, so TCDM latency may vary.
//
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync soft clear)
//   enable_i, ch_en_i, burst_len_i     scheduler configuration
//   dbg_active_i, dbg_step_i           debug hold / single-step token
//   in_*                               per-channel TCDM slave side
//   out_*                              shared TCDM master side
//   cur_ch_o, beat_o, outst_o, err_o   status
module tcdm_seq_mux #(
    parameter int unsigned NB_CH     = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        enable_i,
    input  logic [NB_CH-1:0]            ch_en_i,
    input  logic [NB_CH*CNT_W-1:0]      burst_len_i,
    input  logic                        dbg_active_i,
    input  logic                        dbg_step_i,
    input  logic [NB_CH-1:0]            in_req_i,
    input  logic [NB_CH*AW-1:0]         in_add_i,
    input  logic [NB_CH-1:0]            in_wen_i,
    input  logic [NB_CH*(DW/8)-1:0]     in_be_i,
    input  logic [NB_CH*DW-1:0]         in_data_i,
    output logic [NB_CH-1:0]            in_gnt_o,
    output logic [NB_CH-1:0]            in_r_valid_o,
    output logic [NB_CH*DW-1:0]         in_r_data_o,
    output logic                        out_req_o,
    output logic [AW-1:0]               out_add_o,
    output logic                        out_wen_o,
    output logic [DW/8-1:0]             out_be_o,
    output logic [DW-1:0]               out_data_o,
    input  logic                        out_gnt_i,
    input  logic                        out_r_valid_i,
    input  logic [DW-1:0]               out_r_data_i,
    output logic [$clog2(NB_CH)-1:0]    cur_ch_o,
    output logic [CNT_W-1:0]            beat_o,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                        err_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = $clog2(NB_CH);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [SW-1:0]    r_sel;
    logic [CNT_W-1:0] r_beat;
    logic             r_tok;
    logic             r_dbg;
    logic             r_err;
    logic [SW-1:0]    r_fifo [MAX_OUTST];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [OW-1:0]    r_cnt;

    logic             w_live;
    logic             w_hold;
    logic             w_room;
    logic             w_perm;
    logic             w_req;
    logic             w_gnt;
    logic             w_skip;
    logic             w_pop;
    logic             w_err;
    logic [SW-1:0]    w_head;
    logic [SW-1:0]    w_next;
    logic             w_found;
    logic [CNT_W-1:0] w_blen;
    logic [CNT_W-1:0] w_blen_eff;
    logic [CNT_W-1:0] w_beat_inc;
    logic             w_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Nothing issues or routes while reset or clear is applied, so no grant
    // can be lost against the ID FIFO being emptied.
    assign w_live = !rst_i && !clear_i;
    assign w_hold = dbg_active_i && !r_tok;
    // A response popping this cycle frees a slot for a same-cycle issue.
    assign w_room = (r_cnt < OW'(MAX_OUTST)) || out_r_valid_i;
    assign w_perm = w_live && enable_i && ch_en_i[r_sel] && !w_hold && w_room;
    assign w_req  = w_perm && in_req_i[r_sel];
    assign w_gnt  = w_req && out_gnt_i;
    assign w_skip = !ch_en_i[r_sel] && (|ch_en_i) && !w_hold;

    // Request mux from the selected channel; zero when not issuing.
    always_comb begin
        out_req_o  = w_req;
        out_add_o  = '0;
        out_wen_o  = 1'b0;
        out_be_o   = '0;
        out_data_o = '0;
        in_gnt_o   = '0;
        if (w_req) begin
            out_add_o  = in_add_i[r_sel*AW +: AW];
            out_wen_o  = in_wen_i[r_sel];
            out_be_o   = in_be_i[r_sel*BW +: BW];
            out_data_o = in_data_i[r_sel*DW +: DW];
        end
        if (w_gnt) begin
            in_gnt_o = NB_CH'(1) << r_sel;
        end
    end

    // Next enabled channel, cyclic search starting after r_sel.
    always_comb begin
        w_next  = r_sel;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NB_CH; k++) begin
            if (!w_found && ch_en_i[(32'(r_sel) + k) % NB_CH]) begin
                w_next  = SW'((32'(r_sel) + k) % NB_CH);
                w_found = 1'b1;
            end
        end
    end

    assign w_blen     = burst_len_i[r_sel*CNT_W +: CNT_W];
    assign w_blen_eff = (w_blen == '0) ? CNT_W'(1) : w_blen;
    assign w_beat_inc = (r_beat == '1) ? r_beat : r_beat + 1'b1;
    assign w_last     = (w_beat_inc >= w_blen_eff);

    // Response routing through the head of the ID FIFO.
    assign w_pop  = out_r_valid_i && (r_cnt != '0);
    assign w_err  = out_r_valid_i && (r_cnt == '0);
    assign w_head = r_fifo[r_rptr];

    always_comb begin
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        if (w_live && w_pop) begin
            in_r_valid_o = NB_CH'(1) << w_head;
        end
        if (w_live && out_r_valid_i) begin
            in_r_data_o = {NB_CH{out_r_data_i}};
        end
    end

    // Scheduler: channel selection and beat counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sel  <= '0;
            r_beat <= '0;
        end else if (clear_i) begin
            r_sel  <= '0;
            r_beat <= '0;
        end else if (w_gnt) begin
            if (w_last) begin
                r_sel  <= w_next;
                r_beat <= '0;
            end else begin
                r_beat <= w_beat_inc;
            end
        end else if (w_skip) begin
            r_sel  <= w_next;
            r_beat <= '0;
        end
    end

    // Debug step token: a step wins over a same-cycle consuming grant,
    // leaving debug mode drops any unused token.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tok <= 1'b0;
            r_dbg <= 1'b0;
        end else begin
            r_dbg <= dbg_active_i;
            if (clear_i) begin
                r_tok <= 1'b0;
            end else if (r_dbg && !dbg_active_i) begin
                r_tok <= 1'b0;
            end else if (dbg_step_i) begin
                r_tok <= 1'b1;
            end else if (w_gnt) begin
                r_tok <= 1'b0;
            end
        end
    end

    // In-order channel-ID FIFO and sticky orphan-response error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_fifo[r_wptr] <= r_sel;
                r_wptr         <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_cnt <= r_cnt + OW'(w_gnt) - OW'(w_pop);
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cur_ch_o = r_sel;
    assign beat_o   = r_beat;
    assign outst_o  = r_cnt;
    assign err_o    = r_err;

endmodule

// File: tb/tb_tcdm_seq_mux.sv
// Scoreboard bench for tcdm_seq_mux: directed phases push expected grants and
// responses; monitors pop and compare whenever the DUT grants or responds.
module tb_tcdm_seq_mux;

    logic         clk = 1'b0;
    logic         rst, clear, enable, dbg_active, dbg_step;
    logic [3:0]   ch_en, in_req, in_wen, in_gnt, in_r_valid;
    logic [31:0]  burst_len;
    logic [127:0] in_add, in_data, in_r_data;
    logic [15:0]  in_be;
    logic         out_req, out_wen, out_gnt, out_r_valid;
    logic [31:0]  out_add, out_data, out_r_data;
    logic [3:0]   out_be;
    logic [1:0]   cur_ch, outst;
    logic [7:0]   beat;
    logic         err;

    // TCDM response model / manual response drive
    logic         rsp_en, model_rv, man_rv;
    logic [31:0]  model_rd, man_rd;
    int           lat;

    int tests = 0;
    int fails = 0;
    int exp_g[$];
    int exp_r[$];

    assign out_r_valid = rsp_en ? model_rv : man_rv;
    assign out_r_data  = rsp_en ? model_rd : man_rd;

    always #5 clk = ~clk;

    tcdm_seq_mux dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
        .ch_en_i(ch_en), .burst_len_i(burst_len),
        .dbg_active_i(dbg_active), .dbg_step_i(dbg_step),
        .in_req_i(in_req), .in_add_i(in_add), .in_wen_i(in_wen),
        .in_be_i(in_be), .in_data_i(in_data),
        .in_gnt_o(in_gnt), .in_r_valid_o(in_r_valid), .in_r_data_o(in_r_data),
        .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen),
        .out_be_o(out_be), .out_data_o(out_data),
        .out_gnt_i(out_gnt), .out_r_valid_i(out_r_valid), .out_r_data_i(out_r_data),
        .cur_ch_o(cur_ch), .beat_o(beat), .outst_o(outst), .err_o(err)
    );

    function automatic logic [31:0] ch_add(input int c);
        return 32'h4000_0000 + 32'(c) * 32'h100;
    endfunction
    function automatic logic [31:0] ch_data(input int c);
        return 32'hD000_0000 | 32'(c);
    endfunction
    function automatic logic [3:0] ch_be(input int c);
        return 4'hF >> c;
    endfunction
    function automatic logic ch_wen(input int c);
        return (c % 2) == 1;
    endfunction
    function automatic logic [31:0] rdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_g(input int c, input bit with_rsp);
        exp_g.push_back(c);
        if (with_rsp) exp_r.push_back(c);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drain_chk(input string nm);
        chk(nm, 128'(exp_g.size() + exp_r.size()), 128'(0));
    endtask

    // Grant monitor
    initial begin
        int c;
        forever begin
            @(negedge clk);
            if (out_req && out_gnt) begin
                if (exp_g.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL gnt_unexpected: got grant on %0h expected none", in_gnt);
                end else begin
                    c = exp_g.pop_front();
                    chk("gnt_onehot", 128'(in_gnt), 128'(4'b1 << c));
                    chk("gnt_add", 128'(out_add), 128'(ch_add(c)));
                    chk("gnt_payload", 128'({out_wen, out_be, out_data}),
                        128'({ch_wen(c), ch_be(c), ch_data(c)}));
                end
            end
        end
    end

    // Response monitor
    initial begin
        int c;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (|in_r_valid) begin
                if (exp_r.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got r_valid %0h expected none", in_r_valid);
                end else begin
                    c = exp_r.pop_front();
                    d = rdata(ch_add(c));
                    chk("rsp_onehot", 128'(in_r_valid), 128'(4'b1 << c));
                    chk("rsp_data", in_r_data, {d, d, d, d});
                end
            end
        end
    end

    // TCDM responder: fixed latency pipeline of granted addresses.
    initial begin
        logic        pv [4];
        logic [31:0] pd [4];
        logic        gv;
        logic [31:0] ga;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        model_rv = 1'b0;
        model_rd = '0;
        forever begin
            @(negedge clk);
            gv = out_req && out_gnt;
            ga = out_add;
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0]    = gv;
            pd[0]    = rdata(ga);
            model_rv = pv[lat-1];
            model_rd = pd[lat-1];
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b0; dbg_active = 1'b0; dbg_step = 1'b0;
        ch_en = 4'h0; in_req = 4'h0; burst_len = '0; out_gnt = 1'b0;
        rsp_en = 1'b1; man_rv = 1'b0; man_rd = '0; lat = 1;
        for (int c = 0; c < 4; c++) begin
            in_add[c*32 +: 32]  = ch_add(c);
            in_data[c*32 +: 32] = ch_data(c);
            in_be[c*4 +: 4]     = ch_be(c);
            in_wen[c]           = ch_wen(c);
        end
        #2;
        chk("reset_state", 128'({cur_ch, beat, outst, err, out_req, in_gnt, in_r_valid}), 128'(0));
        cyc(2);
        rst = 1'b0;

        // Phase 1: plain round-robin, burst 1, all enabled
        enable = 1'b1; ch_en = 4'hF; burst_len = {8'd1, 8'd1, 8'd1, 8'd1};
        out_gnt = 1'b1; lat = 1;
        push_g(0, 1); push_g(1, 1); push_g(2, 1); push_g(3, 1); push_g(0, 1);
        in_req = 4'hF;
        cyc(5);
        in_req = 4'h0;
        settle();
        chk("p1_cur_ch", 128'(cur_ch), 128'(1));
        cyc(4);
        drain_chk("p1_drain");

        // Phase 2: weighted sequence, ch2 disabled, ch3 burst 0 acts as 1
        clear = 1'b1; ch_en = 4'b1011; burst_len = {8'd0, 8'd2, 8'd1, 8'd3};
        cyc(1);
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int s8 [8] = '{0, 0, 0, 1, 3, 0, 0, 0};
            push_g(s8[i], 1);
        end
        in_req = 4'hF;
        cyc(8);
        in_req = 4'h0;
        settle();
        chk("p2_cur_ch", 128'(cur_ch), 128'(1));
        chk("p2_beat", 128'(beat), 128'(0));
        cyc(4);
        drain_chk("p2_drain");

        // Phase 3: outstanding limit with 3-cycle response latency
        clear = 1'b1; ch_en = 4'hF; burst_len = {8'd1, 8'd1, 8'd1, 8'd1}; lat = 3;
        cyc(1);
        clear = 1'b0;
        push_g(0, 1); push_g(1, 1); push_g(2, 1); push_g(3, 1);
        in_req = 4'hF;
        cyc(2);
        settle();
        chk("p3_stall_req", 128'(out_req), 128'(0));
        chk("p3_stall_outst", 128'(outst), 128'(2));
        cyc(1);
        settle();
        chk("p3_resume_req", 128'(out_req), 128'(1));
        chk("p3_first_rsp", 128'(in_r_valid), 128'(4'b0001));
        cyc(2);
        in_req = 4'h0;
        cyc(6);
        drain_chk("p3_drain");
        chk("p3_outst_idle", 128'(outst), 128'(0));

        // Phase 4: debug hold and single step
        clear = 1'b1; dbg_active = 1'b1; lat = 1;
        cyc(1);
        clear = 1'b0;
        in_req = 4'hF;
        cyc(10);
        settle();
        chk("p4_hold_req", 128'(out_req), 128'(0));
        chk("p4_hold_ch", 128'(cur_ch), 128'(0));
        out_gnt = 1'b0; dbg_step = 1'b1;
        cyc(1);
        dbg_step = 1'b0;
        settle();
        chk("p4_tok_req", 128'(out_req), 128'(1));
        cyc(1);
        out_gnt = 1'b1;
        push_g(0, 1);
        cyc(1);
        settle();
        chk("p4_step_ch", 128'(cur_ch), 128'(1));
        chk("p4_tok_used", 128'(out_req), 128'(0));
        cyc(3);
        chk("p4_step_once", 128'(cur_ch), 128'(1));
        in_req = 4'h0; dbg_active = 1'b0;
        cyc(3);
        drain_chk("p4_drain");

        // Phase 5: orphan response, then soft clear
        rsp_en = 1'b0; man_rd = 32'hDEAD_BEEF; man_rv = 1'b1;
        settle();
        chk("p5_no_route", 128'(in_r_valid), 128'(0));
        cyc(1);
        man_rv = 1'b0;
        settle();
        chk("p5_err_set", 128'(err), 128'(1));
        cyc(2);
        chk("p5_err_sticky", 128'(err), 128'(1));
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        settle();
        chk("p5_clear", 128'({err, cur_ch, outst}), 128'(0));

        // Phase 6: async reset mid-burst with two outstanding
        burst_len = {8'd3, 8'd3, 8'd3, 8'd3};
        push_g(0, 0); push_g(0, 0);
        in_req = 4'hF;
        cyc(2);
        settle();
        chk("p6_pre_outst", 128'(outst), 128'(2));
        chk("p6_pre_beat", 128'(beat), 128'(2));
        rst = 1'b1;
        #1;
        chk("p6_async_rst", 128'({cur_ch, beat, outst, err, out_req, in_gnt, in_r_valid, out_add}), 128'(0));
        cyc(1);
        rst = 1'b0; in_req = 4'h0; man_rv = 1'b1;
        settle();
        chk("p6_orphan_route", 128'(in_r_valid), 128'(0));
        cyc(1);
        man_rv = 1'b0;
        settle();
        chk("p6_orphan_err", 128'(err), 128'(1));
        drain_chk("p6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tcdm_seq_mux.md
Name: tcdm_seq_mux

Overview:
- Parametrised successor of the streamer's single-port TCDM time-multiplexer.
- Shares one TCDM master port among NB_CH stream ports using a programmable weighted round-robin sequence: per-channel enable and per-channel burst length.
- Routes responses through an in-order channel-ID FIFO, so TCDM response latency may be variable with up to MAX_OUTST outstanding transactions.
- Adds a sticky debug single-step token.
- Sits between the streamer's source/sink TCDM ports and the engine's TCDM master.

Parameters:
- NB_CH, 4, number of multiplexed channels (2..16).
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- CNT_W, 8, burst-length and beat-counter width.
- MAX_OUTST, 2, depth of the outstanding-response ID FIFO (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- clear_i  in  1  synchronous soft clear.
- enable_i  in  1  global issue enable.
- ch_en_i  in  NB_CH  per-channel participation enable.
- burst_len_i  in  NB_CH*CNT_W  grants per channel visit; 0 is treated as 1.
- dbg_active_i  in  1  debug mode: hold scheduler.
- dbg_step_i  in  1  pulse that grants one step token.
- in_req_i  in  NB_CH  channel requests.
- in_add_i  in  NB_CH*AW  channel addresses.
- in_wen_i  in  NB_CH  channel write-enable-n.
- in_be_i  in  NB_CH*DW/8  channel byte enables.
- in_data_i  in  NB_CH*DW  channel write data.
- in_gnt_o  out  NB_CH  channel grants.
- in_r_valid_o  out  NB_CH  channel response valids.
- in_r_data_o  out  NB_CH*DW  channel response data (broadcast).
- out_req_o  out  1  TCDM request.
- out_add_o  out  AW  TCDM address.
- out_wen_o  out  1  TCDM write-enable-n.
- out_be_o  out  DW/8  TCDM byte enables.
- out_data_o  out  DW  TCDM write data.
- out_gnt_i  in  1  TCDM grant.
- out_r_valid_i  in  1  TCDM response valid.
- out_r_data_i  in  DW  TCDM response data.
- cur_ch_o  out  $clog2(NB_CH)  channel currently selected (sel_q).
- beat_o  out  CNT_W  beats granted in current visit.
- outst_o  out  $clog2(MAX_OUTST+1)  outstanding count.
- err_o  out  1  sticky: response received with ID FIFO empty.

Behaviour:
- Reset (rst_i=1) and clear_i both set: sel_q=0, beat_q=0, ID FIFO empty, step token=0, err_o=0. All outputs are then 0; out_* are 0 while not issuing.
- clear_i has priority over all other synchronous updates.
- Issue permission, perm:
  - perm = enable_i & ch_en_i[sel_q] & (!dbg_active_i | tok_q) & (outst<MAX_OUTST | out_r_valid_i).
  - A same-cycle pop frees a FIFO slot.
- Request path is combinational from channel sel_q:
  - out_req_o = perm & in_req_i[sel_q]; out_add/wen/be/data mirror channel sel_q when out_req_o=1, else 0.
  - in_gnt_o[sel_q] = out_req_o & out_gnt_i; all other grant bits are 0.
- On grant (out_req_o & out_gnt_i):
  - Push sel_q into the ID FIFO.
  - beat_n = beat_q+1.
  - If beat_n >= max(burst_len[sel_q],1): advance sel_q to the next enabled channel (cyclic search from sel_q+1, wrapping, possibly back to sel_q itself) and clear beat_q.
  - Otherwise beat_q = beat_n.
- Disabled current channel (ch_en_i[sel_q]=0, some channel enabled, not in debug hold):
  - Advance to the next enabled channel in one cycle; beat_q=0; no request issued.
- No channel enabled: hold sel_q, out_req_o=0.
- Idle channel (in_req_i[sel_q]=0) with its channel enabled: hold sel_q. Strict sequence, no work-conserving skip.
- Response path:
  - On out_r_valid_i, pop the FIFO head h; in_r_valid_o[h]=1; in_r_data_o = out_r_data_i for all channels.
  - Push and pop in the same cycle keep outst unchanged.
- Response with FIFO empty:
  - Set err_o (sticky until clear/reset); no in_r_valid_o asserted; FIFO is not modified.
- Debug:
  - While dbg_active_i=1 and tok_q=0: no requests, sel_q and beat_q held, outstanding responses still routed.
  - dbg_step_i sets tok_q. A grant consumes it.
  - dbg_step_i coincident with a consuming grant leaves tok_q=1.
  - dbg_active_i falling clears tok_q.
  - A disabled-channel advance does not consume the token.
- Latency:
  - Request to TCDM: 0 cycles (combinational).
  - Scheduler update: 1 cycle after grant.
  - Response routing: combinational from out_r_valid_i.
- Width: beat_q saturates at its maximum value (never wraps). Comparisons are unsigned.

Test Plan:
- NB_CH=4, all enabled, burst_len=1, all req high, gnt always 1 -> grant order 0,1,2,3,0; out_add follows channel addresses each cycle.
- burst_len={3,1,2,1}, ch_en=4'b1011 -> grant sequence 0,0,0,1,3,0,0,0; channel 2 is never granted.
- MAX_OUTST=2, gnt=1, r_valid delayed 3 cycles -> out_req_o drops after 2 grants. The first response routes to channel 0 and the second to channel 1; issue resumes in the same cycle as the pop.
- dbg_active_i=1, req high -> no out_req_o for 10 cycles. One dbg_step_i pulse with gnt held 0 for 2 cycles, then 1 -> exactly one grant; cur_ch_o increments once.
- r_valid with empty FIFO -> err_o=1 and all in_r_valid_o=0. clear_i -> err_o=0, cur_ch_o=0, outst_o=0.
- rst_i asserted mid-burst with 2 outstanding -> all outputs 0 asynchronously. A later r_valid sets err_o.
